// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin two-master arbiter in front of peripheral_bus; unpopulated slots are rejected locally
module periph_bus_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int SLOT_MIN   = 1,
  parameter int SLOT_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [DATA_WIDTH-1:0] bus_read_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [4:0] SMIN = 5'(SLOT_MIN);
  localparam logic [4:0] SMAX = 5'(SLOT_MAX);
  state_t state_q, state_d;
  logic win_q, win_d, last_q, last_d, we_q, we_d, err_q, err_d, pick;
  logic [4:0] slot;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  always_comb begin
    pick    = (m0_req && m1_req) ? ~last_q : m1_req;
    slot    = pick ? m1_addr[12:8] : m0_addr[12:8];
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m0_req || m1_req) begin
        state_d = ISSUE;
        win_d   = pick;
        we_d    = pick ? m1_we : m0_we;
        addr_d  = pick ? m1_addr : m0_addr;
        wdata_d = pick ? m1_wdata : m0_wdata;
        err_d   = slot < SMIN || slot > SMAX;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        rdata_d = (!we_q && !err_q) ? bus_read_data : '0;
      end
      default: begin
        state_d = IDLE;
        last_d  = win_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // strobes and acks decode from the registered state, so reset clears them on the same edge
  assign bus_address    = addr_q;
  assign bus_write_data = wdata_q;
  assign bus_we   = state_q == ISSUE && we_q && !err_q;
  assign bus_re   = state_q == ISSUE && !we_q && !err_q;
  assign m0_ack   = state_q == DONE && !win_q;
  assign m1_ack   = state_q == DONE && win_q;
  assign m0_err   = m0_ack && err_q;
  assign m1_err   = m1_ack && err_q;
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed scenarios against a registered peripheral_bus read model
module tb_periph_bus_arbiter;
  logic clk, rst_n;
  logic m0_req, m0_we, m0_ack, m0_err, m1_req, m1_we, m1_ack, m1_err;
  logic [13:0] m0_addr, m1_addr, bus_address;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_write_data, bus_read_data, rd_val;
  logic bus_we, bus_re;
  int errors, checks;

  periph_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_we(bus_we), .bus_re(bus_re), .bus_read_data(bus_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read data is registered and only meaningful after re; otherwise return junk
  initial bus_read_data = 32'h0;
  always @(posedge clk) bus_read_data <= bus_re ? rd_val : 32'hBAD0BAD0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b%b exp 00", m0_ack, m1_ack); end
    checks++; if (m0_err !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b exp 00", m0_err, m1_err); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h exp 0", m0_rdata, m1_rdata); end
    checks++; if (bus_we !== 1'b0 || bus_re !== 1'b0) begin errors++; $display("FAIL reset_strobe: got we=%b re=%b exp 0", bus_we, bus_re); end
    checks++; if (bus_address !== 14'h0 || bus_write_data !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h %h exp 0", bus_address, bus_write_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    rd_val = 32'hDEADBEEF;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0304;
    step();
    checks++; if (bus_re !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL rd_c1_strobe: got re=%b we=%b exp re=1 we=0", bus_re, bus_we); end
    checks++; if (bus_address !== 14'h0304) begin errors++; $display("FAIL rd_c1_addr: got %h exp 0304", bus_address); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rd_c1_ack: got %b exp 0", m0_ack); end
    step();
    checks++; if (bus_re !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL rd_c2: got re=%b ack=%b exp 0 0", bus_re, m0_ack); end
    step();
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL rd_c3_ack: got m0=%b m1=%b exp 1 0", m0_ack, m1_ack); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3_rdata: got %h exp DEADBEEF", m0_rdata); end
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL rd_c3_err: got %b exp 0", m0_err); end
    m0_req = 1'b0;
    step();
    checks++; if (m0_ack !== 1'b0 || bus_re !== 1'b0) begin errors++; $display("FAIL rd_c4: got ack=%b re=%b exp 0 0", m0_ack, bus_re); end
    checks++; if (bus_address !== 14'h0304) begin errors++; $display("FAIL rd_hold_addr: got %h exp 0304", bus_address); end
  endtask

  task automatic test_write();
    rd_val = 32'h55555555;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0800; m1_wdata = 32'h000000A5;
    step();
    checks++; if (bus_we !== 1'b1 || bus_re !== 1'b0) begin errors++; $display("FAIL wr_c1_strobe: got we=%b re=%b exp we=1 re=0", bus_we, bus_re); end
    checks++; if (bus_address !== 14'h0800 || bus_write_data !== 32'hA5) begin errors++; $display("FAIL wr_c1_bus: got %h %h exp 0800 000000a5", bus_address, bus_write_data); end
    step();
    checks++; if (bus_we !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL wr_c2: got we=%b ack=%b exp 0 0", bus_we, m1_ack); end
    step();
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL wr_c3_ack: got m1=%b m0=%b exp 1 0", m1_ack, m0_ack); end
    checks++; if (m1_rdata !== 32'h0 || m1_err !== 1'b0) begin errors++; $display("FAIL wr_c3_resp: got rdata=%h err=%b exp 0 0", m1_rdata, m1_err); end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd_val = 32'h0000CAFE;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0200;
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++; if (m0_ack !== (c == 3 || c == 11)) begin errors++; $display("FAIL rr_m0_ack c%0d: got %b exp %b", c, m0_ack, (c == 3 || c == 11)); end
      checks++; if (m1_ack !== (c == 7 || c == 15)) begin errors++; $display("FAIL rr_m1_ack c%0d: got %b exp %b", c, m1_ack, (c == 7 || c == 15)); end
      if (c == 15) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
  endtask

  task automatic test_err();
    logic [13:0] bad [2];
    bad[0] = 14'h0000;
    bad[1] = 14'h0900;
    rd_val = 32'h13579BDF;
    for (int k = 0; k < 2; k++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = bad[k];
      for (int c = 1; c <= 3; c++) begin
        step();
        checks++; if (bus_re !== 1'b0 || bus_we !== 1'b0) begin errors++; $display("FAIL err%0d_strobe c%0d: got re=%b we=%b exp 0 0", k, c, bus_re, bus_we); end
      end
      checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b1) begin errors++; $display("FAIL err%0d_ack: got ack=%b err=%b exp 1 1", k, m0_ack, m0_err); end
      checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata: got %h exp 0", k, m0_rdata); end
      m0_req = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    rd_val = 32'h12345678;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0104; m0_wdata = 32'h0000BEEF;
    step();
    step();
    rst_n = 1'b0;
    m0_req = 1'b0;
    step();
    checks++; if (m0_ack !== 1'b0 || m0_rdata !== 32'h0 || bus_re !== 1'b0) begin errors++; $display("FAIL rstmid_out: got ack=%b rdata=%h re=%b exp 0", m0_ack, m0_rdata, bus_re); end
    checks++; if (bus_address !== 14'h0 || bus_write_data !== 32'h0) begin errors++; $display("FAIL rstmid_bus: got %h %h exp 0 0", bus_address, bus_write_data); end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (m0_ack !== 1'b0 || bus_re !== 1'b0) begin errors++; $display("FAIL rstmid_quiet c%0d: got ack=%b re=%b exp 0 0", c, m0_ack, bus_re); end
    end
    rd_val = 32'h0BADF00D;
    m0_req = 1'b1; m0_addr = 14'h0104;
    step();
    checks++; if (bus_re !== 1'b1) begin errors++; $display("FAIL rstmid_re: got %b exp 1", bus_re); end
    step();
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rstmid_early_ack: got %b exp 0", m0_ack); end
    step();
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_resp: got ack=%b rdata=%h exp 1 0badf00d", m0_ack, m0_rdata); end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    rd_val = 32'h11111111;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0200;
    step();
    checks++; if (bus_re !== 1'b1 || bus_address !== 14'h0200) begin errors++; $display("FAIL b2b_c1: got re=%b addr=%h exp 1 0200", bus_re, bus_address); end
    m0_addr = 14'h0204;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0300; m1_wdata = 32'h00000077;
    step();
    checks++; if (bus_address !== 14'h0200) begin errors++; $display("FAIL b2b_latch: got %h exp 0200", bus_address); end
    step();
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_c3: got m0=%b m1=%b rdata=%h exp 1 0 11111111", m0_ack, m1_ack, m0_rdata); end
    step();
    step();
    checks++; if (bus_we !== 1'b1 || bus_re !== 1'b0 || bus_address !== 14'h0300 || bus_write_data !== 32'h77) begin errors++; $display("FAIL b2b_c5: got we=%b re=%b addr=%h wd=%h exp 1 0 0300 00000077", bus_we, bus_re, bus_address, bus_write_data); end
    step();
    step();
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL b2b_c7: got m1=%b m0=%b exp 1 0", m1_ack, m0_ack); end
    m1_req = 1'b0;
    rd_val = 32'h22222222;
    step();
    step();
    checks++; if (bus_re !== 1'b1 || bus_address !== 14'h0204) begin errors++; $display("FAIL b2b_c9: got re=%b addr=%h exp 1 0204", bus_re, bus_address); end
    step();
    step();
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_c11: got ack=%b rdata=%h exp 1 22222222", m0_ack, m0_rdata); end
    m0_req = 1'b0;
    step();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; rd_val = 32'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 14'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 14'h0; m1_wdata = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
